ncore_secure_ctrl: RTL and testbench



---
 rtl/ncore_pkg.sv | 26 ++
 rtl/ncore_down_counter.sv | 23 ++
 rtl/ncore_secure_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ncore_secure_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ncore_pkg.sv
// Shared types and defaults for the ncore secure-mode controller.
package ncore_pkg;

  typedef enum logic [2:0] {
    ST_NOKEY,
    ST_NORMAL,
    ST_CHECK,
    ST_SECURE,
    ST_LOCKOUT
  } state_e;

  localparam logic [3:0] OP_ENT   = 4'd7;
  localparam logic [3:0] OP_EXT   = 4'd8;
  localparam logic [3:0] OP_MOVFS = 4'd13;

  localparam int DEF_KEY_W         = 14;
  localparam int DEF_MAX_FAILS     = 3;
  localparam int DEF_LOCK_CYCLES   = 1024;
  localparam int DEF_EMODE_TIMEOUT = 4096;

  // Width needed to hold n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ncore_down_counter.sv
// Loadable down counter that saturates at zero; used for emode timeout and lockout.
module ncore_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (i_load)             r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ncore_secure_ctrl.sv
// Secure-mode controller: ENT key check with brute-force lockout, emode timeout,
// and gatekeeper for the safe ROM.
module ncore_secure_ctrl
  import ncore_pkg::*;
#(
  parameter int KEY_W         = DEF_KEY_W,
  parameter int MAX_FAILS     = DEF_MAX_FAILS,
  parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
  parameter int EMODE_TIMEOUT = DEF_EMODE_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_valid_i,
  input  logic             ent_req_i,
  input  logic [31:0]      ent_val_i,
  input  logic             ext_req_i,
  output logic             ent_done_o,
  output logic             ent_ok_o,
  input  logic             rom_req_i,
  input  logic [7:0]       rom_addr_i,
  output logic             rom_rvalid_o,
  output logic [7:0]       rom_rdata_o,
  output logic             rom_err_o,
  output logic             rom_en_o,
  output logic [7:0]       rom_addr_o,
  input  logic [7:0]       rom_data_i,
  output logic             emode_o,
  output logic             locked_o,
  output logic [2:0]       fail_cnt_o
);

  localparam int TO_W = cnt_w(EMODE_TIMEOUT);
  localparam int LK_W = cnt_w(LOCK_CYCLES);
  localparam bit TO_EN = (EMODE_TIMEOUT > 0);
  // Counters are loaded with N-1 so the state changes exactly N cycles after entry.
  localparam logic [TO_W-1:0] TO_LD = TO_W'((EMODE_TIMEOUT > 0) ? EMODE_TIMEOUT - 1 : 0);
  localparam logic [LK_W-1:0] LK_LD = LK_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]      MAXF  = 3'(MAX_FAILS);

  state_e           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_key;
  logic [31:0]      r_cand;
  logic [2:0]       r_fail, w_fail_nxt, w_fail_inc;
  logic             r_done, r_ok, w_done_nxt, w_ok_nxt;
  logic             w_key_ld, w_cand_ld, w_to_ld, w_lk_ld;
  logic             w_to_zero, w_lk_zero, w_match, w_secure;
  logic             r_rvalid, r_rerr, r_rsec;

  assign w_secure   = (r_state == ST_SECURE);
  assign w_match    = (r_cand == 32'(r_key));
  assign w_fail_inc = r_fail + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_ok_nxt    = 1'b0;
    w_fail_nxt  = r_fail;
    w_key_ld    = 1'b0;
    w_cand_ld   = 1'b0;
    w_to_ld     = 1'b0;
    w_lk_ld     = 1'b0;
    case (r_state)
      ST_NOKEY: begin
        w_done_nxt = ent_req_i;
        if (key_valid_i) begin
          w_key_ld    = 1'b1;
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (ent_req_i) begin
          w_cand_ld   = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_done_nxt = 1'b1;
        if (w_match) begin
          w_ok_nxt    = 1'b1;
          w_fail_nxt  = 3'd0;
          w_to_ld     = 1'b1;
          w_state_nxt = ST_SECURE;
        end else begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc >= MAXF) begin
            w_lk_ld     = 1'b1;
            w_state_nxt = ST_LOCKOUT;
          end else begin
            w_state_nxt = ST_NORMAL;
          end
        end
      end
      ST_SECURE: begin
        // Exit beats a same-cycle ENT; a lone ENT refreshes the timeout.
        w_done_nxt = ent_req_i;
        if (ext_req_i) begin
          w_state_nxt = ST_NORMAL;
        end else if (ent_req_i) begin
          w_ok_nxt = 1'b1;
          w_to_ld  = 1'b1;
        end else if (TO_EN && w_to_zero) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_LOCKOUT: begin
        w_done_nxt = ent_req_i;
        if (w_lk_zero) begin
          w_fail_nxt  = 3'd0;
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_NOKEY;
      r_key   <= '0;
      r_cand  <= '0;
      r_fail  <= '0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fail  <= w_fail_nxt;
      r_done  <= w_done_nxt;
      r_ok    <= w_ok_nxt;
      if (w_key_ld)  r_key  <= key_i;
      if (w_cand_ld) r_cand <= ent_val_i;
    end
  end

  ncore_down_counter #(.W(TO_W)) u_to_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_to_ld),
    .i_load_val (TO_LD),
    .i_en       (w_secure),
    .o_zero     (w_to_zero)
  );

  ncore_down_counter #(.W(LK_W)) u_lk_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lk_ld),
    .i_load_val (LK_LD),
    .i_en       (r_state == ST_LOCKOUT),
    .o_zero     (w_lk_zero)
  );

  // ROM path: the macro is only ever driven while SECURE; everything else gets an error.
  assign rom_en_o   = w_secure & rom_req_i;
  assign rom_addr_o = rom_en_o ? rom_addr_i : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rsec   <= 1'b0;
    end else begin
      r_rvalid <= rom_req_i;
      r_rerr   <= rom_req_i & ~w_secure;
      r_rsec   <= rom_en_o;
    end
  end

  assign rom_rvalid_o = r_rvalid;
  assign rom_err_o    = r_rerr;
  assign rom_rdata_o  = r_rsec ? rom_data_i : 8'd0;

  assign ent_done_o = r_done;
  assign ent_ok_o   = r_ok;
  assign emode_o    = w_secure;
  assign locked_o   = (r_state == ST_LOCKOUT);
  assign fail_cnt_o = r_fail;

endmodule

// File: tb/tb_ncore_secure_ctrl.sv
// Directed bench for ncore_secure_ctrl (timeout shortened to 16 cycles).
module tb_ncore_secure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] key_i = '0;
  logic        key_valid_i = 1'b0;
  logic        ent_req_i = 1'b0;
  logic [31:0] ent_val_i = '0;
  logic        ext_req_i = 1'b0;
  logic        ent_done_o, ent_ok_o;
  logic        rom_req_i = 1'b0;
  logic [7:0]  rom_addr_i = '0;
  logic        rom_rvalid_o, rom_err_o, rom_en_o;
  logic [7:0]  rom_rdata_o, rom_addr_o;
  logic [7:0]  rom_data_i = '0;
  logic        emode_o, locked_o;
  logic [2:0]  fail_cnt_o;

  int total = 0;
  int bad   = 0;

  ncore_secure_ctrl #(
    .KEY_W(14), .MAX_FAILS(3), .LOCK_CYCLES(1024), .EMODE_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .key_valid_i(key_valid_i),
    .ent_req_i(ent_req_i), .ent_val_i(ent_val_i), .ext_req_i(ext_req_i),
    .ent_done_o(ent_done_o), .ent_ok_o(ent_ok_o),
    .rom_req_i(rom_req_i), .rom_addr_i(rom_addr_i),
    .rom_rvalid_o(rom_rvalid_o), .rom_rdata_o(rom_rdata_o), .rom_err_o(rom_err_o),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .emode_o(emode_o), .locked_o(locked_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  // Safe-ROM macro model: data = addr ^ 0xA5, one cycle after enable.
  always @(posedge clk) if (rom_en_o) rom_data_i <= rom_addr_o ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle ENT pulse; returns just after the sampling edge.
  task automatic ent(input logic [31:0] v);
    ent_req_i = 1'b1;
    ent_val_i = v;
    step();
    ent_req_i = 1'b0;
  endtask

  // ENT from NORMAL: done must be low after one edge, high after the second.
  task automatic ent_normal(input string tag, input logic [31:0] v, input logic exp_ok);
    ent(v);
    chk({tag, "_d1"}, 32'(ent_done_o), 32'd0);
    step();
    chk({tag, "_done"}, 32'(ent_done_o), 32'd1);
    chk({tag, "_ok"}, 32'(ent_ok_o), 32'(exp_ok));
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_outs", {emode_o, locked_o, fail_cnt_o, ent_done_o, ent_ok_o,
                     rom_rvalid_o, rom_err_o, rom_en_o, rom_rdata_o, rom_addr_o}, 32'd0);
    rst_n = 1'b1;
    step();

    // NOKEY: ENT refused in one cycle, not counted
    ent(32'h1A2B);
    chk("nokey_done", 32'(ent_done_o), 32'd1);
    chk("nokey_ok", 32'(ent_ok_o), 32'd0);
    chk("nokey_fail", 32'(fail_cnt_o), 32'd0);

    key_i = 14'h1A2B; key_valid_i = 1'b1; step();
    key_i = 14'h0000; step();
    key_valid_i = 1'b0;

    ent_normal("ent1", 32'h0000_1A2B, 1'b1);
    chk("ent1_emode", 32'(emode_o), 32'd1);

    rom_req_i = 1'b1; rom_addr_i = 8'h05; #1;
    chk("sec_rom_en", {rom_en_o, rom_addr_o}, {23'd0, 1'b1, 8'h05});
    step();
    rom_req_i = 1'b0;
    chk("sec_rom_rsp", {rom_rvalid_o, rom_err_o, rom_rdata_o}, {22'd0, 2'b10, 8'hA0});

    ext_req_i = 1'b1; step(); ext_req_i = 1'b0;
    chk("ext_emode", 32'(emode_o), 32'd0);
    chk("ext_nodone", 32'(ent_done_o), 32'd0);

    ent_normal("upper", 32'h0001_1A2B, 1'b0);
    chk("upper_fail", 32'(fail_cnt_o), 32'd1);

    rom_req_i = 1'b1; rom_addr_i = 8'h33; #1;
    chk("nrm_rom_en", {rom_en_o, rom_addr_o}, 32'd0);
    step();
    rom_req_i = 1'b0;
    chk("nrm_rom_rsp", {rom_rvalid_o, rom_err_o, rom_rdata_o}, {22'd0, 2'b11, 8'h00});

    ent_normal("bad2", 32'h0, 1'b0);
    chk("bad2_fail", 32'(fail_cnt_o), 32'd2);
    ent_normal("bad3", 32'h1A2A, 1'b0);
    chk("bad3_lock", {locked_o, fail_cnt_o}, {28'd0, 1'b1, 3'd3});

    ent(32'h1A2B);
    chk("lk_done", {ent_done_o, ent_ok_o, locked_o}, 32'b101);

    n = 0;
    while (locked_o && n < 1100) begin step(); n++; end
    chk("lock_len", n, 32'd1023);
    chk("lock_fail0", 32'(fail_cnt_o), 32'd0);

    // Timeout: read in the last SECURE cycle still returns real data
    ent_normal("ent2", 32'h1A2B, 1'b1);
    repeat (15) step();
    chk("to_still", 32'(emode_o), 32'd1);
    rom_req_i = 1'b1; rom_addr_i = 8'h7E;
    step();
    rom_req_i = 1'b0;
    chk("to_exit", 32'(emode_o), 32'd0);
    chk("to_rom", {rom_rvalid_o, rom_err_o, rom_rdata_o}, {22'd0, 2'b10, 8'hDB});

    // ENT while SECURE reloads the timeout
    ent_normal("ent3", 32'h1A2B, 1'b1);
    repeat (10) step();
    ent(32'h0);
    chk("reload_ack", {ent_done_o, ent_ok_o}, 32'b11);
    repeat (15) step();
    chk("reload_still", 32'(emode_o), 32'd1);
    step();
    chk("reload_exit", 32'(emode_o), 32'd0);

    // EXT + ENT in the same cycle: exit wins, ENT refused, not counted
    ent_normal("ent4", 32'h1A2B, 1'b1);
    ext_req_i = 1'b1; ent(32'h1A2B); ext_req_i = 1'b0;
    chk("both", {ent_done_o, ent_ok_o, emode_o, fail_cnt_o}, {26'd0, 3'b100, 3'd0});

    // Reset in the middle of a SECURE read drops the response and forgets the key
    ent_normal("ent5", 32'h1A2B, 1'b1);
    rom_req_i = 1'b1; rom_addr_i = 8'h09; rst_n = 1'b0;
    step();
    chk("rst_mid", {rom_rvalid_o, emode_o, rom_en_o}, 32'd0);
    rom_req_i = 1'b0; rst_n = 1'b1;
    step();
    chk("rst_rvalid", 32'(rom_rvalid_o), 32'd0);
    ent(32'h1A2B);
    chk("rst_nokey", {ent_done_o, ent_ok_o, emode_o}, 32'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
